// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline. It keeps a shadow record of
// destination and timing for E/M/W and decodes the stall and every forwarding select from it.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic [4:0] dst_d,
    input  logic [1:0] tnew_d,
    input  logic [1:0] tuse_rs_d,
    input  logic [1:0] tuse_rt_d,
    input  logic       jpath_d,
    output logic       stall_d,
    output logic [1:0] forward_rs_b,
    output logic [1:0] forward_rt_b,
    output logic [1:0] forward_rs_jr,
    output logic [1:0] forward_rt_ji,
    output logic [1:0] forward_rs_alu,
    output logic [1:0] forward_rt_alu,
    output logic       forward_rt_mem
);

    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic [4:0] e_rs;
    logic [4:0] e_rt;
    logic [1:0] e_tuse_rs;
    logic [1:0] e_tuse_rt;

    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic [4:0] m_rt;
    logic [1:0] m_tuse_rt;

    logic [4:0] w_dst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_dst     <= '0;
            e_tnew    <= '0;
            e_rs      <= '0;
            e_rt      <= '0;
            e_tuse_rs <= TUSE_NONE;
            e_tuse_rt <= TUSE_NONE;
            m_dst     <= '0;
            m_tnew    <= '0;
            m_rt      <= '0;
            m_tuse_rt <= TUSE_NONE;
            w_dst     <= '0;
        end else begin
            w_dst     <= m_dst;
            m_dst     <= e_dst;
            m_tnew    <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            m_rt      <= e_rt;
            m_tuse_rt <= e_tuse_rt;
            if (stall_d) begin
                // Bubble: writes nothing and consumes nothing.
                e_dst     <= '0;
                e_tnew    <= '0;
                e_rs      <= '0;
                e_rt      <= '0;
                e_tuse_rs <= TUSE_NONE;
                e_tuse_rt <= TUSE_NONE;
            end else begin
                e_dst     <= dst_d;
                e_tnew    <= tnew_d;
                e_rs      <= rs_d;
                e_rt      <= rt_d;
                e_tuse_rs <= tuse_rs_d;
                e_tuse_rt <= tuse_rt_d;
            end
        end
    end

    // Index 0 handles the rs operand, index 1 the rt operand.
    logic [4:0] src_d    [2];
    logic [1:0] tuse_d   [2];
    logic [4:0] src_e    [2];
    logic [1:0] tuse_e   [2];
    logic [1:0] b_sel    [2];
    logic [1:0] jr_sel   [2];
    logic [1:0] alu_sel  [2];
    logic [1:0] src_stall;

    assign src_d[0]  = rs_d;
    assign src_d[1]  = rt_d;
    assign tuse_d[0] = tuse_rs_d;
    assign tuse_d[1] = tuse_rt_d;
    assign src_e[0]  = e_rs;
    assign src_e[1]  = e_rt;
    assign tuse_e[0] = e_tuse_rs;
    assign tuse_e[1] = e_tuse_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic d_used;
            logic e_hit;
            logic m_hit;
            logic w_hit;
            logic alu_m_hit;
            logic alu_w_hit;

            assign d_used    = (tuse_d[gi] != TUSE_NONE);
            assign e_hit     = (e_dst != 5'd0) && (e_dst == src_d[gi]);
            assign m_hit     = (m_dst != 5'd0) && (m_dst == src_d[gi]);
            assign w_hit     = (w_dst != 5'd0) && (w_dst == src_d[gi]);
            assign alu_m_hit = (m_dst != 5'd0) && (m_dst == src_e[gi]);
            assign alu_w_hit = (w_dst != 5'd0) && (w_dst == src_e[gi]);

            // The branch comparator has no E-stage source, so any E hit stalls it.
            assign src_stall[gi] = d_used &&
                ((e_hit && (e_tnew > tuse_d[gi])) ||
                 (m_hit && (m_tnew > tuse_d[gi])) ||
                 ((tuse_d[gi] == 2'd0) && !jpath_d && e_hit));

            assign jr_sel[gi] = !d_used                       ? 2'd0 :
                                (e_hit && (e_tnew == 2'd0))   ? 2'd1 :
                                m_hit                         ? 2'd2 :
                                w_hit                         ? 2'd3 : 2'd0;

            assign b_sel[gi]  = !d_used                       ? 2'd0 :
                                (m_hit && (m_tnew == 2'd0))   ? 2'd1 :
                                w_hit                         ? 2'd2 : 2'd0;

            assign alu_sel[gi] = (tuse_e[gi] > 2'd1) ? 2'd0 :
                                 alu_m_hit           ? 2'd1 :
                                 alu_w_hit           ? 2'd2 : 2'd0;
        end
    endgenerate

    assign stall_d        = |src_stall;
    assign forward_rs_b   = b_sel[0];
    assign forward_rt_b   = b_sel[1];
    assign forward_rs_jr  = jr_sel[0];
    assign forward_rt_ji  = jr_sel[1];
    assign forward_rs_alu = alu_sel[0];
    assign forward_rt_alu = alu_sel[1];
    assign forward_rt_mem = (m_tuse_rt == 2'd2) && (w_dst != 5'd0) && (w_dst == m_rt);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle vector table of decoder inputs and expected
// outputs, plus a hand-written sequence for asynchronous reset during a load-use stall.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_d, rt_d, dst_d;
    logic [1:0] tnew_d, tuse_rs_d, tuse_rt_d;
    logic       jpath_d;
    logic       stall_d;
    logic [1:0] forward_rs_b, forward_rt_b, forward_rs_jr, forward_rt_ji;
    logic [1:0] forward_rs_alu, forward_rt_alu;
    logic       forward_rt_mem;

    hazard_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs_d          (rs_d),
        .rt_d          (rt_d),
        .dst_d         (dst_d),
        .tnew_d        (tnew_d),
        .tuse_rs_d     (tuse_rs_d),
        .tuse_rt_d     (tuse_rt_d),
        .jpath_d       (jpath_d),
        .stall_d       (stall_d),
        .forward_rs_b  (forward_rs_b),
        .forward_rt_b  (forward_rt_b),
        .forward_rs_jr (forward_rs_jr),
        .forward_rt_ji (forward_rt_ji),
        .forward_rs_alu(forward_rs_alu),
        .forward_rt_alu(forward_rt_alu),
        .forward_rt_mem(forward_rt_mem)
    );

    always #5 clk = ~clk;

    // {stall, rs_b, rt_b, rs_jr, rt_ji, rs_alu, rt_alu, rt_mem}
    logic [13:0] outs;
    assign outs = {stall_d, forward_rs_b, forward_rt_b, forward_rs_jr, forward_rt_ji,
                   forward_rs_alu, forward_rt_alu, forward_rt_mem};

    localparam logic [13:0] Z       = 14'd0;
    localparam logic [13:0] ALL     = 14'h3fff;
    localparam logic [13:0] RS_DSEL = 14'h1980;
    localparam logic [13:0] RT_DSEL = 14'h0660;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [1:0]  tnew;
        logic [1:0]  tur;
        logic [1:0]  tut;
        logic        jp;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [13:0] ex(input int st, input int rsb, input int rtb, input int rsjr,
                                       input int rtji, input int rsalu, input int rtalu, input int rtm);
        return {1'(st), 2'(rsb), 2'(rtb), 2'(rsjr), 2'(rtji), 2'(rsalu), 2'(rtalu), 1'(rtm)};
    endfunction

    task automatic add(input int rs, input int rt, input int dst, input int tnew,
                       input int tur, input int tut, input int jp, input logic [13:0] exp);
        vec_t v;
        v.rs   = 5'(rs);
        v.rt   = 5'(rt);
        v.dst  = 5'(dst);
        v.tnew = 2'(tnew);
        v.tur  = 2'(tur);
        v.tut  = 2'(tut);
        v.jp   = 1'(jp);
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic nop(input logic [13:0] exp);
        add(0, 0, 0, 0, 3, 3, 0, exp);
    endtask

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] req,
                         input logic [13:0] care);
        checks++;
        if ((act & care) !== (req & care)) begin
            errors++;
            $display("FAIL %s: got %b required %b (care %b)", name, act, req, care);
        end else begin
            $display("ok   %s: outputs %b", name, act);
        end
    endtask

    task automatic drive(input int rs, input int rt, input int dst, input int tnew,
                         input int tur, input int tut, input int jp);
        rs_d      = 5'(rs);
        rt_d      = 5'(rt);
        dst_d     = 5'(dst);
        tnew_d    = 2'(tnew);
        tuse_rs_d = 2'(tur);
        tuse_rt_d = 2'(tut);
        jpath_d   = 1'(jp);
    endtask

    initial begin
        logic [13:0] care;

        // Load-use: one stall, then W->E forward.
        add(29, 0, 8, 2, 1, 3, 0, Z);
        add(8, 9, 10, 1, 1, 1, 0, ex(1,0,0,0,0,0,0,0));
        add(8, 9, 10, 1, 1, 1, 0, Z);
        nop(ex(0,0,0,0,0,2,0,0)); nop(Z); nop(Z);
        // ALU result to branch: one stall, then M forward.
        add(2, 3, 9, 1, 1, 1, 0, Z);
        add(9, 10, 0, 0, 0, 0, 0, ex(1,0,0,0,0,0,0,0));
        add(9, 10, 0, 0, 0, 0, 0, ex(0,1,0,2,0,0,0,0));
        nop(ex(0,0,0,0,0,2,0,0)); nop(Z); nop(Z);
        // Link to jr: no stall, pc_plus8E forward.
        add(0, 0, 31, 0, 3, 3, 0, Z);
        add(31, 0, 0, 0, 0, 3, 1, ex(0,0,0,1,0,0,0,0));
        nop(ex(0,0,0,0,0,1,0,0)); nop(Z); nop(Z);
        // Link to branch: one stall.
        add(0, 0, 31, 0, 3, 3, 0, Z);
        add(31, 0, 0, 0, 0, 0, 0, ex(1,0,0,1,0,0,0,0));
        add(31, 0, 0, 0, 0, 0, 0, ex(0,1,0,2,0,0,0,0));
        nop(ex(0,0,0,0,0,2,0,0)); nop(Z); nop(Z);
        // Load to branch: two stalls, then W forward.
        add(29, 0, 7, 2, 1, 3, 0, Z);
        add(7, 0, 0, 0, 0, 0, 0, ex(1,0,0,0,0,0,0,0));
        add(7, 0, 0, 0, 0, 0, 0, ex(1,0,0,2,0,0,0,0));
        add(7, 0, 0, 0, 0, 0, 0, ex(0,2,0,3,0,0,0,0));
        nop(Z); nop(Z); nop(Z);
        // Newest producer wins: M over W.
        add(1, 2, 5, 1, 1, 1, 0, Z);
        add(5, 3, 5, 1, 1, 1, 0, Z);
        add(5, 4, 6, 1, 1, 1, 0, ex(0,0,0,0,0,1,0,0));
        nop(ex(0,0,0,0,0,1,0,0)); nop(Z); nop(Z);
        // Store data from load, overlapping a load-use stall.
        add(29, 0, 4, 2, 1, 3, 0, Z);
        add(29, 4, 0, 0, 1, 2, 0, Z);
        add(29, 0, 8, 2, 1, 3, 0, Z);
        add(8, 9, 10, 1, 1, 1, 0, ex(1,0,0,0,0,0,0,1));
        add(8, 9, 10, 1, 1, 1, 0, Z);
        nop(ex(0,0,0,0,0,2,0,0)); nop(Z); nop(Z);
        // Register zero never hits; tuse 3 never stalls or forwards.
        add(1, 2, 0, 1, 1, 1, 0, Z);
        add(0, 0, 0, 0, 0, 0, 0, Z);
        add(1, 2, 12, 1, 1, 1, 0, Z);
        add(12, 12, 0, 0, 3, 3, 1, Z);
        add(12, 12, 0, 0, 3, 3, 1, Z);
        nop(Z); nop(Z);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 3, 3, 0);
        #12;
        check("reset_state", outs, Z, ALL);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(int'(vecs[i].rs), int'(vecs[i].rt), int'(vecs[i].dst), int'(vecs[i].tnew),
                  int'(vecs[i].tur), int'(vecs[i].tut), int'(vecs[i].jp));
            #1;
            // D-stage selects are only meaningful here for tuse 0 or 3.
            care = ALL;
            if (vecs[i].tur == 2'd1 || vecs[i].tur == 2'd2) care = care & ~RS_DSEL;
            if (vecs[i].tut == 2'd1 || vecs[i].tut == 2'd2) care = care & ~RT_DSEL;
            check($sformatf("vec%0d", i), outs, vecs[i].exp, care);
        end

        // Asynchronous reset while a load-use stall is active.
        @(negedge clk);
        drive(29, 0, 8, 2, 1, 3, 0);
        @(negedge clk);
        drive(8, 9, 10, 1, 1, 1, 0);
        #1;
        check("ld_use_stall", outs, ex(1,0,0,0,0,0,0,0), ALL);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", outs, Z, ALL);
        @(posedge clk);
        #1;
        check("reset_held", outs, Z, ALL);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_reset", outs, Z, ALL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
